// File: rtl/rx_pkg.sv
// rx_pkg: shared constants for the serial frame receiver.
//   FSM state encodings (3-bit, legacy-compatible localparams)
//   Frame geometry: 4 data bits, 4 instruction bits, 8 payload bits in total
package rx_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;

  localparam int DATA_BITS  = 4;
  localparam int INSTR_BITS = 4;
  localparam int FRAME_BITS = DATA_BITS + INSTR_BITS;

endpackage

// File: rtl/rx_sincronizador.sv
// sincronizador: multi-flop synchroniser for the asynchronous serial line.
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset; chain resets to 1 (idle line level)
//   d_i    - asynchronous input
//   q_o    - synchronised output, STAGES cycles behind d_i
module sincronizador #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Resetting to 1 keeps reset from looking like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rx.sv
// rx: serial frame receiver.
//   Frame, LSB first: start(0), dado[0..3], instrucao[0..3], stop(1). Idle line is 1.
//   clock         - rising-edge clock
//   reset         - asynchronous active-high reset
//   entrada       - serial line
//   dado          - data nibble of the last good frame
//   instrucao     - instruction nibble of the last good frame
//   valido        - one-cycle pulse when dado/instrucao update
//   erro_frame    - one-cycle pulse when the stop bit is sampled low
//   ocupado       - high whenever the FSM is not IDLE
//   stateDebug    - current FSM state
//   bitCountDebug - index of the next bit to sample (0..8)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for the synchronised line to go low
// START     | start bit seen, waiting until mid-bit to confirm it
// DATA      | sampling the 8 payload bits, one every CLKS_PER_BIT cycles
// STOP      | sampling the stop bit; good frame -> outputs, bad -> error
// WAIT_HIGH | framing error seen, waiting for the line to return high
module rx
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  entrada,
  output logic [DATA_BITS-1:0]  dado,
  output logic [INSTR_BITS-1:0] instrucao,
  output logic                  valido,
  output logic                  erro_frame,
  output logic                  ocupado,
  output logic [2:0]            stateDebug,
  output logic [3:0]            bitCountDebug
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

  logic rx_s;

  logic [2:0]            state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [3:0]            bit_q,     bit_d;
  logic [DATA_BITS-1:0]  shift_d_q, shift_d_d;
  logic [INSTR_BITS-1:0] shift_i_q, shift_i_d;
  logic [DATA_BITS-1:0]  dado_q,    dado_d;
  logic [INSTR_BITS-1:0] instr_q,   instr_d;
  logic                  valido_q,  valido_d;
  logic                  erro_q,    erro_d;
  logic                  tick;

  sincronizador #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clock),
    .rst_i (reset),
    .d_i   (entrada),
    .q_o   (rx_s)
  );

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d_d = shift_d_q;
    shift_i_d = shift_i_q;
    dado_d    = dado_q;
    instr_d   = instr_q;
    valido_d  = 1'b0;
    erro_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          bit_d = '0;
          // With one clock per bit there is no mid-point to wait for:
          // the start bit is confirmed in the cycle it is first seen.
          if (HALF == '0) begin
            state_d = DATA;
            cnt_d   = RELOAD;
          end else begin
            state_d = START;
            cnt_d   = HALF;
          end
        end
      end
      START: begin
        if (rx_s) begin
          state_d = IDLE;
        end else if (tick) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = RELOAD;
          if (bit_q[2]) shift_i_d[bit_q[1:0]] = rx_s;
          else          shift_d_d[bit_q[1:0]] = rx_s;
          bit_d = bit_q + 1'b1;
          if (bit_q == LAST_BIT) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          bit_d = '0;
          if (rx_s) begin
            dado_d   = shift_d_q;
            instr_d  = shift_i_q;
            valido_d = 1'b1;
            state_d  = IDLE;
          end else begin
            erro_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT_HIGH: begin
        // A line stuck low must not be mistaken for a new start bit.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_d_q <= '0;
      shift_i_q <= '0;
      dado_q    <= '0;
      instr_q   <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_d_q <= shift_d_d;
      shift_i_q <= shift_i_d;
      dado_q    <= dado_d;
      instr_q   <= instr_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
    end
  end

  assign dado          = dado_q;
  assign instrucao     = instr_q;
  assign valido        = valido_q;
  assign erro_frame    = erro_q;
  assign ocupado       = (state_q != IDLE);
  assign stateDebug    = state_q;
  assign bitCountDebug = bit_q;

endmodule

// File: tb/tb_rx.sv
// tb_rx: scoreboard bench for the serial frame receiver.
module tb_rx;

  typedef struct packed {
    logic       err;
    logic [3:0] d;
    logic [3:0] i;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic line  = 1'b1;
  logic ent8  = 1'b1;
  logic use_tx = 1'b0;
  logic botao = 1'b0;
  logic entrada;

  logic [3:0] dado, instrucao, bitCountDebug;
  logic       valido, erro_frame, ocupado;
  logic [2:0] stateDebug;

  logic [3:0] dado8, instrucao8, bitCountDebug8;
  logic       valido8, erro_frame8, ocupado8;
  logic [2:0] stateDebug8;

  // behavioural transmitter: one bit per clock, triggered by botao
  logic [9:0] tx_sh;
  logic [3:0] tx_cnt;
  logic       tx_busy;
  logic [3:0] tx_d = 4'h9;
  logic [3:0] tx_i = 4'h6;

  exp_t sb[$];
  int   vcyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_pulses = 0;
  int   last_start = 0;
  logic seen_start8 = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_sh   <= '1;
      tx_cnt  <= '0;
      tx_busy <= 1'b0;
    end else if (botao && !tx_busy) begin
      tx_sh   <= {1'b1, tx_i, tx_d, 1'b0};
      tx_cnt  <= 4'd10;
      tx_busy <= 1'b1;
    end else if (tx_busy) begin
      tx_sh  <= {1'b1, tx_sh[9:1]};
      tx_cnt <= tx_cnt - 4'd1;
      if (tx_cnt == 4'd1) tx_busy <= 1'b0;
    end
  end

  assign entrada = use_tx ? tx_sh[0] : line;

  rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .entrada(entrada),
    .dado(dado), .instrucao(instrucao), .valido(valido),
    .erro_frame(erro_frame), .ocupado(ocupado),
    .stateDebug(stateDebug), .bitCountDebug(bitCountDebug)
  );

  rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut8 (
    .clock(clock), .reset(reset), .entrada(ent8),
    .dado(dado8), .instrucao(instrucao8), .valido(valido8),
    .erro_frame(erro_frame8), .ocupado(ocupado8),
    .stateDebug(stateDebug8), .bitCountDebug(bitCountDebug8)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pops an expectation for every pulse the DUT presents
  always @(negedge clock) begin
    if (!reset) begin
      if (stateDebug8 == 3'd1) seen_start8 = 1'b1;
      if (valido && erro_frame) check("valido_erro_exclusive", 1, 0);
      if (valido || erro_frame) begin
        n_pulses++;
        if (sb.size() == 0) begin
          check("unexpected_pulse", int'(valido) + 2 * int'(erro_frame), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_is_error", int'(erro_frame), int'(e.err));
          check("dado", int'(dado), int'(e.d));
          check("instrucao", int'(instrucao), int'(e.i));
          if (valido) vcyc.push_back(cyc);
        end
      end
      if (valido8 || erro_frame8) check("n8_pulse", 1, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [3:0] d, input logic [3:0] i, input logic stop);
    logic [9:0] fr;
    fr = {stop, i, d, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      line = fr[k];
      if (k == 0) last_start = cyc;
    end
  endtask

  task automatic wait_pulses(input int target);
    int k;
    k = 0;
    while (n_pulses < target && k < 200) begin
      @(negedge clock);
      k++;
    end
    check("pulse_arrived", int'(n_pulses >= target), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    idle(2);
    check("rst_dado", int'(dado), 0);
    check("rst_instrucao", int'(instrucao), 0);
    check("rst_valido", int'(valido), 0);
    check("rst_erro", int'(erro_frame), 0);
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_state", int'(stateDebug), 0);
    check("rst_bitcount", int'(bitCountDebug), 0);

    // 1: good frame A/3, latency SYNC_STAGES+10
    sb.push_back('{1'b0, 4'hA, 4'h3});
    send_frame(4'hA, 4'h3, 1'b1);
    line = 1'b1;
    wait_pulses(1);
    if (vcyc.size() >= 1) check("latency", vcyc[$] - last_start, 12);
    idle(3);

    // 2: bad stop bit, outputs keep A/3, stuck-low line never retriggers
    sb.push_back('{1'b1, 4'hA, 4'h3});
    send_frame(4'h5, 4'hC, 1'b0);
    wait_pulses(2);
    idle(20);
    check("stuck_low_state", int'(stateDebug), 4);
    check("stuck_low_ocupado", int'(ocupado), 1);
    check("hold_dado", int'(dado), 10);
    line = 1'b1;
    idle(4);
    check("recover_state", int'(stateDebug), 0);

    // 3: one-cycle glitch at 8 clocks per bit
    @(negedge clock);
    ent8 = 1'b0;
    @(negedge clock);
    ent8 = 1'b1;
    idle(20);
    check("glitch_seen_start", int'(seen_start8), 1);
    check("glitch_state", int'(stateDebug8), 0);
    check("glitch_dado", int'(dado8), 0);

    // 4: back-to-back frames, valid pulses 10 cycles apart
    sb.push_back('{1'b0, 4'h1, 4'hF});
    sb.push_back('{1'b0, 4'hE, 4'h0});
    send_frame(4'h1, 4'hF, 1'b1);
    send_frame(4'hE, 4'h0, 1'b1);
    line = 1'b1;
    wait_pulses(4);
    if (vcyc.size() >= 3) check("b2b_spacing", vcyc[$] - vcyc[$-1], 10);
    idle(3);

    // 5: reset in the middle of a frame
    begin
      logic [9:0] fr;
      fr = {1'b1, 4'h7, 4'h7, 1'b0};
      for (int k = 0; k < 7; k++) begin
        @(negedge clock);
        line = fr[k];
      end
    end
    check("pre_reset_ocupado", int'(ocupado), 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_dado", int'(dado), 0);
    check("midrst_state", int'(stateDebug), 0);
    check("midrst_bitcount", int'(bitCountDebug), 0);
    line = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(3);
    sb.push_back('{1'b0, 4'h7, 4'h7});
    send_frame(4'h7, 4'h7, 1'b1);
    line = 1'b1;
    wait_pulses(5);
    idle(3);

    // 6: transmitter model drives the line
    use_tx = 1'b1;
    sb.push_back('{1'b0, 4'h9, 4'h6});
    @(negedge clock);
    botao = 1'b1;
    @(negedge clock);
    botao = 1'b0;
    wait_pulses(6);
    idle(3);
    check("tx_dado", int'(dado), 9);
    check("tx_instrucao", int'(instrucao), 6);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
